// File: rtl/cfi_flash_wb.sv
// cfi_flash_wb: Wishbone classic slave onto a 16-bit asynchronous CFI NOR flash.
// Define CFI_FLASH_WB_WRITE_EN to drive flash writes; otherwise writes are acked and dropped.
module cfi_flash_wb #(
  parameter int RD_WAIT    = 8,
  parameter int WR_WAIT    = 6,
  parameter int TA         = 2,
  parameter int RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [22:0] flash_adr_o,
  input  logic [15:0] flash_dq_i,
  output logic [15:0] flash_dq_o,
  output logic        flash_dq_oe_o,
  output logic        flash_ce_n_o,
  output logic        flash_oe_n_o,
  output logic        flash_we_n_o,
  output logic        flash_adv_n_o,
  output logic        flash_rst_n_o,
  output logic        flash_clk_o
);

`ifdef CFI_FLASH_WB_WRITE_EN
  localparam logic WR_EN = 1'b1;
`else
  localparam logic WR_EN = 1'b0;
`endif

  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, HOLD, GAP, ACK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] rcnt_q;
  logic          rst_done_q;
  logic [21:0]   base_q;
  logic          half_q;
  logic [31:0]   wdat_q;
  logic [31:0]   rdat_q;
  logic          lo_q;
  logic          we_q;

  logic          accept;
  logic          skip;
  logic          act;
  logic          last_acc;
  logic          last_gap;
  logic [CW-1:0] acc_len;

  assign accept = (state_q == IDLE) && wb_cyc_i
               && wb_stb_i && rst_done_q;
  // writes with nothing to store go straight to ACK
  assign skip = wb_we_i && (!WR_EN || wb_sel_i == 4'h0);
  assign acc_len = we_q ? CW'(WR_WAIT - 1)
                        : CW'(RD_WAIT - 1);
  assign last_acc = cnt_q == acc_len;
  assign last_gap = cnt_q == CW'(TA - 1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = skip ? ACK : SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: if (last_acc) begin
        if (we_q)        state_d = HOLD;
        else if (half_q) state_d = ACK;
        else             state_d = GAP;
      end
      HOLD:   state_d = (!half_q && lo_q) ? GAP : ACK;
      GAP:    if (last_gap) state_d = SETUP;
      ACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end
  end

  // flash reset stretch after system reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q     <= '0;
      rst_done_q <= 1'b0;
    end else if (!rst_done_q) begin
      if (rcnt_q == CW'(RST_CYCLES - 1)) rst_done_q <= 1'b1;
      else rcnt_q <= rcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      half_q <= 1'b0;
      wdat_q <= '0;
      rdat_q <= '0;
      lo_q   <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= wb_adr_i[23:2];
        wdat_q <= wb_dat_i;
        lo_q   <= |wb_sel_i[1:0];
        we_q   <= wb_we_i;
        half_q <= wb_we_i && (wb_sel_i[3:2] == 2'b00);
      end
      if (state_q == ACCESS && last_acc && !we_q) begin
        if (half_q) rdat_q[15:0]  <= flash_dq_i;
        else        rdat_q[31:16] <= flash_dq_i;
      end
      if (state_q == GAP && last_gap) half_q <= 1'b1;
    end
  end

  assign act = (state_q == SETUP) || (state_q == ACCESS)
            || (state_q == HOLD);

  assign flash_ce_n_o  = !act;
  assign flash_oe_n_o  = !(state_q == ACCESS && !we_q);
  assign flash_we_n_o  = !(WR_EN && state_q == ACCESS && we_q);
  assign flash_dq_oe_o = WR_EN && act && we_q;
  assign flash_adr_o   = {base_q, half_q};
  assign flash_dq_o    = half_q ? wdat_q[15:0] : wdat_q[31:16];
  assign flash_adv_n_o = 1'b0;
  assign flash_clk_o   = 1'b0;
  assign flash_rst_n_o = rst_done_q;

  assign wb_ack_o = (state_q == ACK) && wb_cyc_i && wb_stb_i;
  assign wb_dat_o = wb_ack_o ? rdat_q : '0;

endmodule
